crc_read_checker: RTL and testbench
===================================

Name: crc_read_checker

Overview:
- Read-side companion of the CRC write path.
- On a read request, fetches one stored codeword ({data, crc}) from memory and divides it serially through an LFSR by the same generator polynomial used on write.
- Presents the data field with a one-cycle valid strobe and an error flag that is high when the remainder is non-zero.
- Uses the same serial, one-bit-per-cycle timing style as the write-side CRC controller.

Parameters:
- DATA_WIDTH, 8: data field width in bits.
- CRC_WIDTH, 4: CRC field width in bits.
- POLY, 4'h3: generator polynomial low terms (x^4 implicit); the default is x^4+x+1.
- CW_WIDTH, DATA_WIDTH+CRC_WIDTH (12): codeword width. Derived; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset. Asynchronous, active-high, returns block to IDLE.
- read  input  1  read request; sampled only in IDLE.
- mem_rdata  input  CW_WIDTH  codeword from memory. Valid the cycle after read_mem_en, i.e. in LOAD.
- read_mem_en  output  1  one-cycle memory read strobe.
- read_mem_busy  output  1  high in FETCH, LOAD and SHIFT.
- data_out  output  DATA_WIDTH  data field of the last checked codeword.
- data_valid  output  1  one-cycle strobe; data_out and crc_error are valid.
- crc_error  output  1  remainder non-zero for the last checked codeword.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State IDLE, count 0, shift register 0, LFSR 0.
  - data_out 0, crc_error 0.
  - read_mem_en, read_mem_busy and data_valid all 0.
- FSM states: IDLE, FETCH, LOAD, SHIFT, DONE.
  - IDLE -> FETCH when read=1, else stay in IDLE.
  - FETCH -> LOAD unconditionally.
  - LOAD -> SHIFT unconditionally.
  - SHIFT -> DONE when count==CW_WIDTH-1, else stay in SHIFT.
  - DONE -> IDLE unconditionally.
- State outputs (Moore, combinational from state):
  - read_mem_en=1 only in FETCH.
  - read_mem_busy=1 in FETCH, LOAD and SHIFT.
  - data_valid=1 only in DONE.
- LOAD actions:
  - Shift register <= mem_rdata.
  - LFSR <= 0.
  - data_out <= mem_rdata[CW_WIDTH-1:CRC_WIDTH]; this value is captured here and held.
- SHIFT actions, one bit per cycle, MSB first:
  - b = shift register MSB; shift register <<= 1.
  - fb = lfsr[CRC_WIDTH-1] ^ b.
  - lfsr <= {lfsr[CRC_WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
  - count increments each SHIFT cycle and is cleared in every other state.
  - Exactly CW_WIDTH shift cycles occur (count 0..CW_WIDTH-1).
- crc_error update:
  - Registered on the SHIFT->DONE edge as (next lfsr != 0), so it is valid throughout DONE.
  - Held until the next DONE or reset.
- CRC convention: the stored CRC is (data·x^CRC_WIDTH) mod P with initial value 0, matching the write path.
- Latency:
  - Edge 0 samples read=1 (IDLE->FETCH); edge 1 enters LOAD; edge 2 enters SHIFT.
  - Edge 2+CW_WIDTH enters DONE (edge 14 at defaults).
  - data_valid is high during the cycle after edge 14; the block is back in IDLE after edge 15.
- Boundary conditions:
  - read while not in IDLE is ignored; it is not queued.
  - read held high continuously gives back-to-back transactions, a new FETCH every CW_WIDTH+4 cycles (16 at defaults).
  - rst mid-transaction returns the block to IDLE at once and clears all outputs. A partial result is never flagged valid.
  - An all-zero codeword gives crc_error=0.
  - Any single-bit error in the codeword gives crc_error=1.
  - mem_rdata is ignored outside LOAD.

Test Plan:
- Reset, then read=1 for 1 cycle with memory returning 12'h013 in LOAD -> read_mem_en high exactly 1 cycle; busy high for 14 cycles; data_valid pulse on the cycle after edge 14; data_out=8'h01; crc_error=0.
- Codeword 12'h80E -> data_out=8'h80, crc_error=0. Codeword 12'h80F (CRC bit flip) -> crc_error=1. Codeword 12'h00E (data bit flip) -> crc_error=1, data_out=8'h00.
- Codeword 12'h000 -> crc_error=0, data_out=0. Then codeword 12'h001 -> crc_error=1, and the earlier outputs hold until this DONE.
- read pulsed again during SHIFT -> ignored: one data_valid only, and no extra read_mem_en.
- read held high for 40 cycles -> read_mem_en pulses 16 cycles apart; data_valid 16 cycles apart; no overlap.
- rst asserted asynchronously mid-SHIFT (count=5), released 2 cycles later -> outputs 0 immediately; no data_valid. A fresh read then completes normally with 12'h013 -> crc_error=0.

Source files
------------

// File: rtl/crc_read_checker_if.sv
// Read-side CRC checker bus: read request, memory return path and checked result.
interface crc_read_checker_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CRC_WIDTH  = 4
);

  localparam int unsigned CW_WIDTH = DATA_WIDTH + CRC_WIDTH;

  logic                  read;
  logic [CW_WIDTH-1:0]   mem_rdata;
  logic                  read_mem_en;
  logic                  read_mem_busy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  crc_error;

  // Requester side: issues reads and supplies the memory codeword.
  modport master (
    output read,
    output mem_rdata,
    input  read_mem_en,
    input  read_mem_busy,
    input  data_out,
    input  data_valid,
    input  crc_error
  );

  // Checker side.
  modport slave (
    input  read,
    input  mem_rdata,
    output read_mem_en,
    output read_mem_busy,
    output data_out,
    output data_valid,
    output crc_error
  );

endinterface

// File: rtl/crc_read_checker.sv
// Fetches one stored {data, crc} codeword and divides it serially, MSB first,
// through an LFSR; a non-zero remainder flags a CRC error.
module crc_read_checker #(
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          CRC_WIDTH  = 4,
  parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'(4'h3)
) (
  input  logic               clk,
  input  logic               rst,
  crc_read_checker_if.slave  bus
);

  localparam int unsigned CW_WIDTH = DATA_WIDTH + CRC_WIDTH;
  localparam int unsigned CNT_W    = (CW_WIDTH > 1) ? $clog2(CW_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CW_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [CNT_W-1:0]      count_q;
  logic [CW_WIDTH-1:0]   shreg_q;
  logic [CRC_WIDTH-1:0]  lfsr_q;
  logic [CRC_WIDTH-1:0]  lfsr_shift;
  logic                  shift_bit;
  logic                  feedback;

  logic                  read_mem_en_q;
  logic                  read_mem_busy_q;
  logic                  data_valid_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  crc_error_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; read is only honoured from IDLE and never queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.read) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (count_q == LAST_BIT) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One serial division step: next LFSR value for the current codeword MSB.
  always_comb begin
    shift_bit  = shreg_q[CW_WIDTH-1];
    feedback   = lfsr_q[CRC_WIDTH-1] ^ shift_bit;
    lfsr_shift = {lfsr_q[CRC_WIDTH-2:0], 1'b0} ^ (feedback ? POLY : '0);
  end

  // Strobes are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_mem_en_q   <= 1'b0;
      read_mem_busy_q <= 1'b0;
      data_valid_q    <= 1'b0;
    end else begin
      read_mem_en_q   <= (state_d == S_FETCH);
      read_mem_busy_q <= (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_SHIFT);
      data_valid_q    <= (state_d == S_DONE);
    end
  end

  // Datapath: capture codeword in LOAD, divide one bit per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      shreg_q     <= '0;
      lfsr_q      <= '0;
      data_out_q  <= '0;
      crc_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          shreg_q    <= bus.mem_rdata;
          lfsr_q     <= '0;
          data_out_q <= bus.mem_rdata[CW_WIDTH-1:CRC_WIDTH];
          count_q    <= '0;
        end
        S_SHIFT: begin
          shreg_q <= {shreg_q[CW_WIDTH-2:0], 1'b0};
          lfsr_q  <= lfsr_shift;
          if (state_d == S_DONE) begin
            count_q     <= '0;
            crc_error_q <= (lfsr_shift != '0);
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        default: begin
          count_q <= '0;
        end
      endcase
    end
  end

  // Drive the bus from the registered results.
  assign bus.read_mem_en   = read_mem_en_q;
  assign bus.read_mem_busy = read_mem_busy_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.data_out      = data_out_q;
  assign bus.crc_error     = crc_error_q;

endmodule

// File: tb/tb_crc_read_checker.sv
// Bench for crc_read_checker: directed cases plus random codewords checked
// against a polynomial long-division model.
module tb_crc_read_checker;

  localparam int unsigned DW  = 8;
  localparam int unsigned CRW = 4;
  localparam int unsigned CWW = DW + CRW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  crc_read_checker_if #(.DATA_WIDTH(DW), .CRC_WIDTH(CRW)) bus ();

  crc_read_checker #(
    .DATA_WIDTH (DW),
    .CRC_WIDTH  (CRW),
    .POLY       (4'h3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [CWW-1:0] cw;
  logic           prev_en;
  logic [CWW-1:0] exp_q[$];
  logic [DW-1:0]  exp_dout;
  logic           exp_err;

  int en_cnt   = 0;
  int dv_cnt   = 0;
  int busy_cnt = 0;
  int en_cycs[$];
  int dv_cycs[$];

  // Remainder of the codeword polynomial divided by x^4 + x + 1.
  function automatic logic [CRW-1:0] poly_mod(input logic [CWW-1:0] c);
    logic [CWW-1:0] r;
    logic [CWW-1:0] gen;
    r   = c;
    gen = 12'h013;
    for (int i = CWW - 1; i >= int'(CRW); i--) begin
      if (r[i]) r = r ^ (gen << (i - int'(CRW)));
    end
    return r[CRW-1:0];
  endfunction

  function automatic logic [CWW-1:0] good_cw(input logic [DW-1:0] d);
    return {d, poly_mod({d, 4'h0})};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: memory answers in the cycle after read_mem_en, checks at negedge.
  task automatic step();
    logic           served;
    logic [CWW-1:0] e;
    @(posedge clk);
    #1;
    served = 1'b0;
    if (prev_en) begin
      bus.mem_rdata = cw;
      exp_q.push_back(cw);
      served = 1'b1;
    end else begin
      bus.mem_rdata = CWW'($urandom);
    end
    prev_en = bus.read_mem_en;
    @(negedge clk);
    cyc++;
    if (bus.read_mem_en) begin
      en_cnt++;
      en_cycs.push_back(cyc);
    end
    if (bus.read_mem_busy) busy_cnt++;
    chk("valid_busy_exclusive", 32'(bus.data_valid & bus.read_mem_busy), 32'd0);
    if (bus.data_valid) begin
      dv_cnt++;
      dv_cycs.push_back(cyc);
      chk("valid_has_pending_read", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e       = exp_q.pop_front();
        exp_err = (poly_mod(e) != '0);
        chk("data_out_at_valid", 32'(bus.data_out), 32'(e[CWW-1:CRW]));
      end
    end
    chk("data_out", 32'(bus.data_out), 32'(exp_dout));
    chk("crc_error", 32'(bus.crc_error), 32'(exp_err));
    if (served) exp_dout = cw[CWW-1:CRW];
  endtask

  // Single read pulse, 16 cycles until back in IDLE.
  task automatic run_txn(input logic [CWW-1:0] c);
    int en0, dv0, b0;
    cw  = c;
    en0 = en_cnt;
    dv0 = dv_cnt;
    b0  = busy_cnt;
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    repeat (15) step();
    chk("fetch_count", 32'(en_cnt - en0), 32'd1);
    chk("valid_count", 32'(dv_cnt - dv0), 32'd1);
    chk("busy_cycles", 32'(busy_cnt - b0), 32'd14);
    if (en_cycs.size() != 0 && dv_cycs.size() != 0)
      chk("fetch_to_valid", 32'(dv_cycs[$] - en_cycs[$]), 32'd14);
  endtask

  initial begin
    int en0, dv0, n;
    logic [DW-1:0] d;
    int kind;

    bus.read      = 1'b0;
    bus.mem_rdata = '0;
    prev_en       = 1'b0;
    exp_dout      = '0;
    exp_err       = 1'b0;
    cw            = '0;

    // Reset state.
    repeat (2) step();
    chk("rst_read_mem_en", 32'(bus.read_mem_en), 32'd0);
    chk("rst_busy", 32'(bus.read_mem_busy), 32'd0);
    chk("rst_valid", 32'(bus.data_valid), 32'd0);
    rst = 1'b0;
    step();

    // Directed codewords.
    run_txn(12'h013);
    run_txn(12'h80E);
    run_txn(12'h80F);
    run_txn(12'h00E);
    run_txn(12'h000);
    run_txn(12'h001);

    // Read during SHIFT is ignored.
    en0 = en_cnt;
    dv0 = dv_cnt;
    cw  = good_cw(8'h5A);
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    repeat (5) step();
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    repeat (13) step();
    chk("ignored_read_fetches", 32'(en_cnt - en0), 32'd1);
    chk("ignored_read_valids", 32'(dv_cnt - dv0), 32'd1);

    // Read held high for 40 cycles: back-to-back transactions 16 cycles apart.
    en0 = en_cnt;
    dv0 = dv_cnt;
    cw  = good_cw(8'hC3);
    bus.read = 1'b1;
    repeat (40) step();
    bus.read = 1'b0;
    repeat (20) step();
    chk("held_fetches", 32'(en_cnt - en0), 32'd3);
    chk("held_valids", 32'(dv_cnt - dv0), 32'd3);
    n = en_cycs.size();
    if (n >= 3 && dv_cycs.size() >= 3) begin
      chk("held_fetch_gap_a", 32'(en_cycs[n-2] - en_cycs[n-3]), 32'd16);
      chk("held_fetch_gap_b", 32'(en_cycs[n-1] - en_cycs[n-2]), 32'd16);
      chk("held_valid_gap", 32'(dv_cycs[dv_cycs.size()-1] - dv_cycs[dv_cycs.size()-2]), 32'd16);
      chk("held_last_latency", 32'(dv_cycs[dv_cycs.size()-1] - en_cycs[n-1]), 32'd14);
    end

    // Asynchronous reset in the middle of SHIFT (count = 5).
    cw = 12'h013;
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    repeat (7) step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_read_mem_en", 32'(bus.read_mem_en), 32'd0);
    chk("midrst_busy", 32'(bus.read_mem_busy), 32'd0);
    chk("midrst_valid", 32'(bus.data_valid), 32'd0);
    chk("midrst_data_out", 32'(bus.data_out), 32'd0);
    chk("midrst_crc_error", 32'(bus.crc_error), 32'd0);
    exp_q.delete();
    exp_dout = '0;
    exp_err  = 1'b0;
    prev_en  = 1'b0;
    dv0      = dv_cnt;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    chk("midrst_no_valid", 32'(dv_cnt - dv0), 32'd0);
    run_txn(12'h013);

    // Random codewords: clean, single-bit corrupted, or arbitrary.
    for (int t = 0; t < 40; t++) begin
      d    = DW'($urandom);
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      run_txn(good_cw(d));
      else if (kind == 1) run_txn(good_cw(d) ^ (CWW'(1) << $urandom_range(0, CWW - 1)));
      else                run_txn(CWW'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end

    chk("no_lost_results", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
